// File: rtl/mips_cpu_bus_master.sv
// rtl/mips_cpu_bus_master.sv - MIPS CPU memory-port bus initiator with lane steering and load extension
module mips_cpu_bus_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [1:0]        cpu_size_i,
    input  logic              cpu_signed_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic              cpu_busy_o,
    output logic              cpu_done_o,
    output logic              cpu_err_o,
    output logic [31:0]       cpu_rdata_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    output logic [3:0]        byteenable_o,
    output logic [31:0]       writedata_o,
    input  logic              waitrequest_i,
    input  logic [31:0]       readdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        CAPT = 2'b10
    } state_t;

    state_t            state_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        lane_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] address_q;
    logic              read_q;
    logic              write_q;
    logic [3:0]        be_q;
    logic [31:0]       wd_q;

    logic              bad_d;
    logic [3:0]        be_d;
    logic [31:0]       wd_d;
    logic [31:0]       lane_data;
    logic [31:0]       rdata_d;

    // Decode the incoming request: reject bad size/alignment, steer store data onto its lanes
    always_comb begin
        bad_d = 1'b0;
        be_d  = 4'b0000;
        wd_d  = 32'h0;
        case (cpu_size_i)
            2'b00: begin
                be_d = 4'b0001 << cpu_addr_i[1:0];
                wd_d = {24'h0, cpu_wdata_i[7:0]} << {cpu_addr_i[1:0], 3'b000};
            end
            2'b01: begin
                bad_d = cpu_addr_i[0];
                if (cpu_addr_i[1]) begin
                    be_d = 4'b1100;
                    wd_d = {cpu_wdata_i[15:0], 16'h0};
                end else begin
                    be_d = 4'b0011;
                    wd_d = {16'h0, cpu_wdata_i[15:0]};
                end
            end
            2'b10: begin
                bad_d = (cpu_addr_i[1:0] != 2'b00);
                be_d  = 4'b1111;
                wd_d  = cpu_wdata_i;
            end
            default: bad_d = 1'b1;
        endcase
    end

    // Right-justify the addressed lane(s) of the returned word and extend to 32 bits
    always_comb begin
        lane_data = readdata_i >> {lane_q, 3'b000};
        case (size_q)
            2'b00:   rdata_d = signed_q ? {{24{lane_data[7]}}, lane_data[7:0]}
                                        : {24'h0, lane_data[7:0]};
            2'b01:   rdata_d = signed_q ? {{16{lane_data[15]}}, lane_data[15:0]}
                                        : {16'h0, lane_data[15:0]};
            default: rdata_d = readdata_i;
        endcase
    end

    // Transaction FSM; every bus and CPU-side output is a register driven from here
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
            lane_q    <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0;
            address_q <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            be_q      <= 4'b0000;
            wd_q      <= 32'h0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req_i) begin
                        we_q     <= cpu_we_i;
                        size_q   <= cpu_size_i;
                        signed_q <= cpu_signed_i;
                        lane_q   <= cpu_addr_i[1:0];
                        if (bad_d) begin
                            err_q <= 1'b1;
                        end else begin
                            address_q <= {cpu_addr_i[ADDR_W-1:2], 2'b00};
                            be_q      <= be_d;
                            wd_q      <= wd_d;
                            read_q    <= ~cpu_we_i;
                            write_q   <= cpu_we_i;
                            busy_q    <= 1'b1;
                            state_q   <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest_i) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        if (we_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= CAPT;
                        end
                    end
                end
                CAPT: begin
                    rdata_q <= rdata_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_busy_o   = busy_q;
    assign cpu_done_o   = done_q;
    assign cpu_err_o    = err_q;
    assign cpu_rdata_o  = rdata_q;
    assign address_o    = address_q;
    assign read_o       = read_q;
    assign write_o      = write_q;
    assign byteenable_o = be_q;
    assign writedata_o  = wd_q;

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// tb/tb_mips_cpu_bus_master.sv - scoreboard bench for mips_cpu_bus_master
module tb_mips_cpu_bus_master;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        cpu_req_i = 1'b0;
    logic        cpu_we_i = 1'b0;
    logic [1:0]  cpu_size_i = 2'b00;
    logic        cpu_signed_i = 1'b0;
    logic [31:0] cpu_addr_i = 32'h0;
    logic [31:0] cpu_wdata_i = 32'h0;
    logic        waitrequest_i = 1'b0;
    logic [31:0] readdata_i = 32'h0;
    logic        cpu_busy_o, cpu_done_o, cpu_err_o;
    logic [31:0] cpu_rdata_o, address_o, writedata_o;
    logic        read_o, write_o;
    logic [3:0]  byteenable_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ws_left = 0;
    int hi_cnt = 0;
    bit abort_pending = 1'b0;
    logic [31:0] last_rdata = 32'h0;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          len;
    } bus_t;

    resp_t rq[$];
    bus_t  bq[$];

    mips_cpu_bus_master #(.ADDR_W(32)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_size_i(cpu_size_i),
        .cpu_signed_i(cpu_signed_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_busy_o(cpu_busy_o), .cpu_done_o(cpu_done_o), .cpu_err_o(cpu_err_o),
        .cpu_rdata_o(cpu_rdata_o), .address_o(address_o), .read_o(read_o),
        .write_o(write_o), .byteenable_o(byteenable_o), .writedata_o(writedata_o),
        .waitrequest_i(waitrequest_i), .readdata_i(readdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Responder: holds waitrequest high for ws_left bus cycles, then accepts
    always @(negedge clk_i) begin
        if (read_o || write_o) begin
            waitrequest_i = (ws_left > 0);
            if (ws_left > 0) ws_left--;
        end else begin
            waitrequest_i = 1'b0;
        end
    end

    // Bus monitor: every active bus cycle must match the expected transaction
    always @(negedge clk_i) begin : mon_bus
        if (!reset_i) begin
            if (read_o || write_o) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bus: read=%0b write=%0b addr=%h, required no bus activity",
                             read_o, write_o, address_o);
                end else begin
                    chk("bus_rw", {30'h0, read_o, write_o}, {30'h0, !bq[0].we, bq[0].we});
                    chk("bus_address", address_o, bq[0].addr);
                    chk("bus_byteenable", {28'h0, byteenable_o}, {28'h0, bq[0].be});
                    if (bq[0].we) chk("bus_writedata", writedata_o, bq[0].wd);
                end
                hi_cnt++;
            end else if (hi_cnt > 0) begin
                if (bq.size() != 0) begin
                    if (abort_pending) abort_pending = 1'b0;
                    else chk("bus_cycles", hi_cnt, bq[0].len);
                    void'(bq.pop_front());
                end
                hi_cnt = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every done/err pulse
    always @(negedge clk_i) begin : mon_resp
        resp_t r;
        if (!reset_i && (cpu_done_o || cpu_err_o)) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response: done=%0b err=%0b, required none", cpu_done_o, cpu_err_o);
            end else begin
                r = rq.pop_front();
                chk("resp_err", cpu_err_o, r.err);
                chk("resp_done", cpu_done_o, !r.err);
                chk("resp_rdata", cpu_rdata_o, r.rdata);
                chk("resp_cycle", cyc, r.cyc);
                chk("resp_busy_low", cpu_busy_o, 0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: %0d responses and %0d bus transactions outstanding, required 0",
                     rq.size(), bq.size());
            rq.delete();
            bq.delete();
        end
    endtask

    task automatic issue(input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdval,
                         input int ws, input bit bad, input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] ld_exp);
        resp_t r;
        bus_t  b;
        wait_idle();
        @(negedge clk_i);
        cpu_we_i     = we;
        cpu_size_i   = size;
        cpu_signed_i = sgn;
        cpu_addr_i   = addr;
        cpu_wdata_i  = wdata;
        readdata_i   = rdval;
        ws_left      = ws;
        cpu_req_i    = 1'b1;
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
        chk("busy_after_sample", cpu_busy_o, bad ? 0 : 1);
        r.err   = bad;
        r.rdata = (bad || we) ? last_rdata : ld_exp;
        r.cyc   = cyc + (bad ? 0 : ((we ? 1 : 2) + ws));
        last_rdata = r.rdata;
        rq.push_back(r);
        if (!bad) begin
            b.we   = we;
            b.addr = {addr[31:2], 2'b00};
            b.be   = be;
            b.wd   = wd;
            b.len  = ws + 1;
            bq.push_back(b);
        end
    endtask

    initial begin
        bus_t b;
        #3;
        chk("reset_ctrl", {27'h0, read_o, write_o, cpu_busy_o, cpu_done_o, cpu_err_o}, 32'h0);
        chk("reset_byteenable", {28'h0, byteenable_o}, 32'h0);
        chk("reset_address", address_o, 32'h0);
        chk("reset_writedata", writedata_o, 32'h0);
        chk("reset_rdata", cpu_rdata_o, 32'h0);
        @(negedge clk_i);
        reset_i = 1'b0;

        //    we    size   sgn  addr          wdata         readdata      ws bad be       wd            load result
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 0, 4'b1111, 32'h0,        32'hDEADBEEF);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0,        32'h80123456, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80);
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0,        32'h80123456, 0, 0, 4'b1000, 32'h0,        32'h00000080);
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0302, 32'h0000BEEF, 32'h0,        0, 0, 4'b1100, 32'hBEEF0000, 32'h0);

        issue(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0,        32'h12345678, 3, 0, 4'b1111, 32'h0,        32'h12345678);
        @(negedge clk_i);
        cpu_addr_i = 32'h0000_0500;
        cpu_we_i   = 1'b1;
        cpu_req_i  = 1'b1;
        @(negedge clk_i);
        cpu_req_i  = 1'b0;

        issue(1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h11111111, 32'h0,        0, 1, 4'b0000, 32'h0,        32'h0);

        issue(1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h000000AB, 32'h0,        0, 0, 4'b0010, 32'h0000AB00, 32'h0);
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h123456C3, 32'h0,        0, 0, 4'b1000, 32'hC3000000, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0,        32'h80017FFF, 0, 0, 4'b1100, 32'h0,        32'hFFFF8001);
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0,        32'h1234F00D, 1, 0, 4'b0011, 32'h0,        32'h0000F00D);
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0,        32'h00007F00, 0, 0, 4'b0010, 32'h0,        32'h0000007F);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_010C, 32'hCAFEF00D, 32'h0,        2, 0, 4'b1111, 32'hCAFEF00D, 32'h0);
        issue(1'b0, 2'b10, 1'b1, 32'h0000_0000, 32'h0,        32'h80000000, 0, 0, 4'b1111, 32'h0,        32'h80000000);

        // Reset during a stalled read: the transaction is dropped without a response
        wait_idle();
        @(negedge clk_i);
        cpu_we_i   = 1'b0;
        cpu_size_i = 2'b10;
        cpu_addr_i = 32'h0000_0200;
        ws_left    = 1000;
        cpu_req_i  = 1'b1;
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
        b.we = 1'b0;
        b.addr = 32'h0000_0200;
        b.be = 4'b1111;
        b.wd = 32'h0;
        b.len = 0;
        abort_pending = 1'b1;
        bq.push_back(b);
        repeat (2) @(negedge clk_i);
        chk("stalled_read_high", read_o, 1);
        @(posedge clk_i);
        #2;
        reset_i = 1'b1;
        #1;
        chk("reset_drops_bus", {27'h0, read_o, write_o, cpu_busy_o, cpu_done_o, cpu_err_o}, 32'h0);
        ws_left = 0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        last_rdata = 32'h0;
        @(negedge clk_i);
        chk("post_reset_rdata", cpu_rdata_o, 32'h0);
        chk("post_reset_idle", cpu_busy_o, 0);

        issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0,        32'h0BADCAFE, 0, 0, 4'b1111, 32'h0,        32'h0BADCAFE);

        wait_idle();
        repeat (5) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus_master.md
# mips_cpu_bus_master

Bus initiator for the MIPS CPU's memory port. It converts one CPU-side load/store request (address, size, signedness, store data) into a single transaction on the shared read/write/byteenable/waitrequest memory bus. It handles byte-lane steering, waitrequest stalls, one-cycle read latency capture and load sign/zero extension. It sits between the CPU datapath and the bus memory model or interconnect, and drives the bus signals the memory responder consumes.

## Interface
- ADDR_W, 32, CPU-side byte address width; bus address is the same width.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- cpu_signed  in  1  load extension: 1 = sign, 0 = zero.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data, right-justified.
- cpu_busy  out  1  high in any state other than IDLE.
- cpu_done  out  1  one-cycle pulse: transaction complete.
- cpu_err  out  1  one-cycle pulse: misaligned or illegal request rejected.
- cpu_rdata  out  32  extended load result; holds until the next load completes.
- address  out  ADDR_W  word-aligned bus address: cpu_addr with [1:0] = 00.
- read  out  1  bus read request.
- write  out  1  bus write request.
- byteenable  out  4  active lanes.
- writedata  out  32  lane-steered store data.
- waitrequest  in  1  responder stall.
- readdata  in  32  valid the cycle after a read is accepted.

## Operation
- States: IDLE, BUS, CAPT.
- **IDLE, cpu_req = 1.** The block latches all cpu_* inputs, then checks the request:
  - Misaligned: half with addr[0] = 1, or word with addr[1:0] ≠ 00.
  - Illegal: size = 11.
  - A misaligned or illegal request pulses cpu_err next cycle, stays in IDLE and issues no bus activity.
  - A valid request goes to BUS.
- **IDLE, cpu_req = 0.** No action.
- **BUS.** The block drives read = ~we and write = we, plus address, byteenable and writedata, all from latched values. These are stable until acceptance.
- **Acceptance.** A transaction is accepted on a rising edge in BUS with waitrequest = 0.
  - Store: go to IDLE and pulse cpu_done.
  - Load: go to CAPT.
- **CAPT.** read and write are low. At the end of the cycle, readdata is extracted and registered into cpu_rdata, cpu_done pulses, and the state returns to IDLE.
- **Lane rules (k = addr[1:0]):**
  - Byte: byteenable = 1 << k; writedata has wdata[7:0] on lane k and zeros elsewhere.
  - Half: byteenable = 0011 at k = 0, 1100 at k = 2; wdata[15:0] goes on that lane pair.
  - Word: byteenable = 1111; writedata = wdata.
- **Load extraction.** The selected lane(s) are right-justified, then sign- or zero-extended to 32 bits per cpu_signed. A word load ignores cpu_signed.
- **cpu_req while busy.** Ignored and not queued. The requester must wait for cpu_done or cpu_err.
- **read and write.** Never high simultaneously. Both are low outside BUS.

## Timing
- Reset values (asynchronous, immediate): state IDLE; read, write, cpu_busy, cpu_done, cpu_err = 0; byteenable = 0; address, writedata, cpu_rdata = 0.
- Reset mid-transaction drops the transaction, with no done or err pulse. Bus requests deassert immediately.
- Zero-wait load: req sampled at edge 0, read high in cycle 1, accepted at edge 1, CAPT in cycle 2, cpu_done and cpu_rdata valid in cycle 3.
- Zero-wait store: write high in cycle 1, cpu_done in cycle 2.
- Each waitrequest-high cycle at an acceptance edge adds exactly one cycle. Latency is unbounded while waitrequest stays high.
- cpu_err is asserted in cycle 1 after the sampling edge.
- cpu_busy is low during the cycle in which cpu_done or cpu_err is high, so a new request may be sampled at the end of that cycle.

## Test plan
- **Word load:** addr 0x100, waitrequest = 0, readdata 0xDEADBEEF in CAPT. Required: read high 1 cycle, byteenable 1111, address 0x100; cpu_rdata = 0xDEADBEEF with cpu_done in cycle 3.
- **Signed byte load:** addr 0x203, readdata 0x80123456. Required: byteenable 1000, address 0x200, cpu_rdata = 0xFFFFFF80. The same request unsigned gives 0x00000080.
- **Half store:** addr 0x302, wdata 0x0000BEEF. Required: write high, byteenable 1100, writedata 0xBEEF0000, address 0x300, cpu_done in cycle 2.
- **Wait states:** word load with waitrequest high for 3 cycles. Required: read, address and byteenable stable for 4 cycles; cpu_done in cycle 6; cpu_req pulsed during BUS has no effect.
- **Misaligned request:** half load at 0x101, then size = 11. Required: cpu_err pulse in cycle 1 for each; read and write never asserted; cpu_rdata unchanged.
- **Reset in BUS:** assert reset mid-cycle during a stalled read. Required: read falls the same cycle, no cpu_done, state IDLE; the next request completes normally.
